// File: rtl/lrck_rate_detector_pkg.sv
// Shared types and constant tables for the LRCK sample-rate detector.
// Rate classes are ordered by ascending fs, so nominal periods descend with the index.
package lrck_rate_detector_pkg;

  typedef enum logic [1:0] {
    BR_X1 = 2'd0,
    BR_X2 = 2'd1,
    BR_X4 = 2'd2,
    BR_X8 = 2'd3
  } bitrate_t;

  typedef struct packed {
    logic     valid;
    logic     fam;
    bitrate_t mult;
  } rate_class_t;

  localparam logic [1:0] DET_IDLE    = 2'd0;
  localparam logic [1:0] DET_ARMED   = 2'd1;
  localparam logic [1:0] DET_MEASURE = 2'd2;
  localparam logic [1:0] DET_LOCKED  = 2'd3;

  localparam int RATE_HZ [8] = '{44100, 48000, 88200, 96000, 176400, 192000, 352800, 384000};

  function automatic logic [31:0] win_lo(input int idx, input int clk_hz, input int tol);
    return 32'((clk_hz / RATE_HZ[idx[2:0]]) * (1000 - tol) / 1000);
  endfunction

  function automatic logic [31:0] win_hi(input int idx, input int clk_hz, input int tol);
    return 32'((clk_hz / RATE_HZ[idx[2:0]]) * (1000 + tol) / 1000);
  endfunction

  // Odd indices are the 48k family; index pairs map to x1, x2, x4, x8.
  function automatic rate_class_t classify(input logic [31:0] p, input int clk_hz, input int tol);
    rate_class_t c;
    c = '{valid: 1'b0, fam: 1'b0, mult: BR_X1};
    for (int i = 0; i < 8; i++) begin
      if (p >= win_lo(i, clk_hz, tol) && p <= win_hi(i, clk_hz, tol)) begin
        c.valid = 1'b1;
        c.fam   = i[0];
        c.mult  = bitrate_t'(i[2:1]);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/lrck_edge_sync.sv
// Two-flop synchroniser for the asynchronous LRCK plus a rising-edge strobe.
// Strobe is high for one clk, two clk after the pin rises; no backpressure.
module lrck_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_lrck,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_lrck;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/lrck_rate_detector.sv
// Measures the LRCK period, classifies it into family/multiple and qualifies it with lock hysteresis.
// A lrck pin edge reaches the lock outputs 2 sync + 3 clk later; no backpressure.
module lrck_rate_detector
  import lrck_rate_detector_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TOL_PPT     = 20,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CW          = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_lrck,
  output logic          o_locked,
  output bitrate_t      o_bitrate,
  output logic          o_fam_48,
  output logic [CW-1:0] o_period,
  output logic          o_rate_change
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  // Adjacent windows must leave a gap, otherwise a period could hit two classes.
  for (genvar g = 0; g < 7; g++) begin : g_win_chk
    if (win_lo(g, CLK_HZ, TOL_PPT) <= win_hi(g + 1, CLK_HZ, TOL_PPT)) begin : g_overlap
      $error("lrck_rate_detector: class windows %0d and %0d overlap", g, g + 1);
    end
  end

  logic          w_edge;
  logic          w_timeout;
  logic          w_edge_acc;
  logic          w_same;
  logic [MW-1:0] w_match_nxt;
  logic [MW-1:0] w_miss_nxt;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_period;
  logic          r_edge_d1;
  logic          r_edge_d2;
  rate_class_t   r_class;
  logic [1:0]    r_state;
  logic [MW-1:0] r_match;
  logic [MW-1:0] r_miss;
  rate_class_t   r_cand;
  logic          r_locked;
  bitrate_t      r_bitrate;
  logic          r_fam;
  logic          r_rate_change;

  lrck_edge_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_lrck  (i_lrck),
    .o_edge  (w_edge)
  );

  // Timeout fires on the cycle that carries cnt to TIMEOUT_CYC and swallows a coincident edge.
  assign w_timeout  = (r_state != DET_IDLE) && (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_edge_acc = w_edge & ~w_timeout;

  always_comb begin
    w_same      = r_class.valid && (r_class == r_cand);
    w_match_nxt = '0;
    if (r_class.valid) begin
      w_match_nxt = w_same ? (r_match + MW'(1)) : MW'(1);
    end
    w_miss_nxt = w_same ? '0 : (r_miss + MW'(1));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_period  <= '0;
      r_edge_d1 <= 1'b0;
      r_edge_d2 <= 1'b0;
      r_class   <= '0;
    end else begin
      if (w_edge_acc) begin
        r_cnt <= CW'(1);
        if (r_state != DET_IDLE) begin
          r_period <= r_cnt;
        end
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_edge_d1 <= w_edge_acc;
      r_edge_d2 <= r_edge_d1;
      r_class   <= classify(32'(r_period), CLK_HZ, TOL_PPT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= DET_IDLE;
      r_match       <= '0;
      r_miss        <= '0;
      r_cand        <= '0;
      r_locked      <= 1'b0;
      r_bitrate     <= BR_X1;
      r_fam         <= 1'b0;
      r_rate_change <= 1'b0;
    end else begin
      r_rate_change <= 1'b0;
      if (w_timeout) begin
        r_state  <= DET_IDLE;
        r_locked <= 1'b0;
        r_match  <= '0;
        r_miss   <= '0;
      end else if (r_edge_d2) begin
        case (r_state)
          DET_IDLE: r_state <= DET_ARMED;
          DET_ARMED, DET_MEASURE: begin
            r_match <= w_match_nxt;
            if (r_class.valid) begin
              r_cand <= r_class;
            end
            if (w_match_nxt == MW'(LOCK_CNT)) begin
              r_state       <= DET_LOCKED;
              r_locked      <= 1'b1;
              r_bitrate     <= r_class.mult;
              r_fam         <= r_class.fam;
              r_rate_change <= 1'b1;
              r_miss        <= '0;
            end else begin
              r_state <= DET_MEASURE;
            end
          end
          DET_LOCKED: begin
            // Outputs deliberately keep the last locked class after losing lock.
            if (w_miss_nxt == MW'(LOCK_CNT)) begin
              r_state  <= DET_MEASURE;
              r_locked <= 1'b0;
              r_match  <= '0;
              r_miss   <= '0;
            end else begin
              r_miss <= w_miss_nxt;
            end
          end
          default: r_state <= DET_IDLE;
        endcase
      end
    end
  end

  assign o_locked      = r_locked;
  assign o_bitrate     = r_bitrate;
  assign o_fam_48      = r_fam;
  assign o_period      = r_period;
  assign o_rate_change = r_rate_change;

endmodule
